ls_arbiter: RTL and testbench

LS_ARBITER -- requirements
Module: ls_arbiter

---
 rtl/ls_arbiter.sv | 131 +++++++++++++
 tb/tb_ls_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ls_arbiter.sv
// Local-store port arbiter: shares one single-ported SRAM between odd-pipe load/store and
// instruction fetch, with starvation-driven fetch priority and a fixed 2-cycle read pipeline.
module ls_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ldst_req,
   input  logic          ldst_we,
   input  logic [0:31]   ldst_lsa,
   input  logic [0:127]  ldst_wdata,
   input  logic [0:6]    ldst_rt_addr,
   output logic          ldst_ack,
   output logic          ldst_rvalid,
   output logic [127:0]  ldst_rdata,
   output logic [6:0]    ldst_rt_addr_out,
   input  logic          if_req,
   input  logic [0:31]   if_lsa,
   output logic          if_ack,
   output logic          if_rvalid,
   output logic [127:0]  if_rdata,
   input  logic          flush,
   output logic          ls_en,
   output logic          ls_we,
   output logic [0:10]   ls_addr,
   output logic [127:0]  ls_wdata,
   input  logic [127:0]  ls_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {NORMAL, FETCH_PRI} state_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] starve_cnt;
   logic [3:0] starve_cnt_next;
   logic       ldst_ok;
   logic       fetch_ok;
   logic       s1_ld_valid;
   logic       s1_if_valid;
   logic [6:0] s1_rt_addr;
   logic       unused_lsa_bits;

   // Line index comes from lsa[17:27]; the remaining address bits are don't-care.
   assign unused_lsa_bits = ^{ldst_lsa[0:16], ldst_lsa[28:31], if_lsa[0:16], if_lsa[28:31]};

   assign ldst_ok  = ldst_req & ~reset;
   assign fetch_ok = if_req & ~flush & ~reset;

   always_comb begin
      ldst_ack = 1'b0;
      if_ack   = 1'b0;
      if (state == FETCH_PRI) begin
         if_ack   = fetch_ok;
         ldst_ack = ldst_ok & ~fetch_ok;
      end else begin
         ldst_ack = ldst_ok;
         if_ack   = fetch_ok & ~ldst_ok;
      end
   end

   // Fetch priority is entered on the cycle the counter would reach the limit, so the next cycle favours fetch.
   always_comb begin
      starve_cnt_next = starve_cnt;
      state_next      = state;
      if (if_ack || !if_req || flush) begin
         starve_cnt_next = 4'd0;
      end else if (ldst_ack) begin
         starve_cnt_next = starve_cnt + 4'd1;
      end
      case (state)
         NORMAL: begin
            if (starve_cnt_next >= LIMIT) begin
               state_next = FETCH_PRI;
            end
         end
         FETCH_PRI: begin
            if (if_ack || flush) begin
               state_next = NORMAL;
            end
         end
         default: state_next = NORMAL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= NORMAL;
         starve_cnt <= 4'd0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_cnt_next;
      end
   end

   assign ls_en    = ldst_ack | if_ack;
   assign ls_we    = ldst_ack & ldst_we;
   assign ls_addr  = ldst_ack ? ldst_lsa[17:27] : if_lsa[17:27];
   assign ls_wdata = (ldst_ack && ldst_we) ? ldst_wdata : '0;

   // Stage 1 tracks the grant while the SRAM reads; stage 2 captures the data and raises rvalid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_ld_valid      <= 1'b0;
         s1_if_valid      <= 1'b0;
         s1_rt_addr       <= 7'd0;
         ldst_rvalid      <= 1'b0;
         if_rvalid        <= 1'b0;
         ldst_rdata       <= '0;
         if_rdata         <= '0;
         ldst_rt_addr_out <= 7'd0;
      end else begin
         s1_ld_valid <= ldst_ack & ~ldst_we;
         s1_if_valid <= if_ack;
         if (ldst_ack) begin
            s1_rt_addr <= ldst_rt_addr;
         end
         ldst_rvalid <= s1_ld_valid;
         if_rvalid   <= s1_if_valid & ~flush;
         if (s1_ld_valid) begin
            ldst_rdata       <= ls_rdata;
            ldst_rt_addr_out <= s1_rt_addr;
         end
         if (s1_if_valid && !flush) begin
            if_rdata <= ls_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ls_arbiter.sv
// Directed bench for ls_arbiter with a behavioural local-store SRAM (one-cycle read latency).
module tb_ls_arbiter;

   logic          clk;
   logic          reset;
   logic          ldst_req;
   logic          ldst_we;
   logic [31:0]   ldst_lsa;
   logic [127:0]  ldst_wdata;
   logic [6:0]    ldst_rt_addr;
   logic          ldst_ack;
   logic          ldst_rvalid;
   logic [127:0]  ldst_rdata;
   logic [6:0]    ldst_rt_addr_out;
   logic          if_req;
   logic [31:0]   if_lsa;
   logic          if_ack;
   logic          if_rvalid;
   logic [127:0]  if_rdata;
   logic          flush;
   logic          ls_en;
   logic          ls_we;
   logic [10:0]   ls_addr;
   logic [127:0]  ls_wdata;
   logic [127:0]  ls_rdata;

   logic [127:0]  mem [2048];
   int            checks;
   int            passes;

   ls_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .ldst_req(ldst_req), .ldst_we(ldst_we), .ldst_lsa(ldst_lsa),
      .ldst_wdata(ldst_wdata), .ldst_rt_addr(ldst_rt_addr),
      .ldst_ack(ldst_ack), .ldst_rvalid(ldst_rvalid), .ldst_rdata(ldst_rdata),
      .ldst_rt_addr_out(ldst_rt_addr_out),
      .if_req(if_req), .if_lsa(if_lsa), .if_ack(if_ack),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .flush(flush),
      .ls_en(ls_en), .ls_we(ls_we), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_rdata(ls_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ls_en) begin
         if (ls_we) mem[ls_addr] <= ls_wdata;
         else       ls_rdata <= mem[ls_addr];
      end
   end

   function automatic logic [127:0] pattern(input int line);
      return {4{32'hC0DE_0000 | 32'(line)}};
   endfunction

   // Expected grant pattern with both requesters held and STARVE_LIMIT=4 for cycles 0..9.
   function automatic logic starveLd(input int c);
      return (c >= 0) && (c < 10) && (c != 4) && (c != 9);
   endfunction

   function automatic logic starveIf(input int c);
      return (c == 4) || (c == 9);
   endfunction

   task automatic applyStimulus(input logic lreq, input logic lwe, input logic [31:0] llsa,
                                input logic [127:0] wd, input logic [6:0] rt,
                                input logic ireq, input logic [31:0] ilsa, input logic fl);
      ldst_req     = lreq;
      ldst_we      = lwe;
      ldst_lsa     = llsa;
      ldst_wdata   = wd;
      ldst_rt_addr = rt;
      if_req       = ireq;
      if_lsa       = ilsa;
      flush        = fl;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks = checks + 1;
      assert (obs === exp) passes = passes + 1;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic stepCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      applyStimulus(0, 0, 32'h0, 128'h0, 7'd0, 0, 32'h0, 0);
   endtask

   task automatic loadCheck(input string tag);
      applyStimulus(1, 0, 32'h0000_0123, 128'h0, 7'd5, 0, 32'h0, 0);
      @(negedge clk);
      checkOutput({tag, "_ack"}, ldst_ack, 1);
      checkOutput({tag, "_if_ack"}, if_ack, 0);
      checkOutput({tag, "_ls_en"}, ls_en, 1);
      checkOutput({tag, "_ls_we"}, ls_we, 0);
      checkOutput({tag, "_ls_addr"}, ls_addr, 11'h012);
      stepCycle();
      idle();
      @(negedge clk);
      checkOutput({tag, "_rvalid_n1"}, ldst_rvalid, 0);
      stepCycle();
      @(negedge clk);
      checkOutput({tag, "_rvalid_n2"}, ldst_rvalid, 1);
      checkOutput({tag, "_rdata"}, ldst_rdata, pattern(12'h012));
      checkOutput({tag, "_rt"}, ldst_rt_addr_out, 7'd5);
      stepCycle();
      @(negedge clk);
      checkOutput({tag, "_rvalid_n3"}, ldst_rvalid, 0);
      checkOutput({tag, "_rdata_hold"}, ldst_rdata, pattern(12'h012));
      stepCycle();
   endtask

   initial begin
      checks = 0;
      passes = 0;
      for (int i = 0; i < 2048; i++) mem[i] = pattern(i);
      ls_rdata = '0;

      // Reset with requests pending: nothing may be granted.
      reset = 1'b1;
      applyStimulus(1, 1, 32'h40, 128'h1, 7'd1, 1, 32'h80, 0);
      @(negedge clk);
      checkOutput("rst_ldst_ack", ldst_ack, 0);
      checkOutput("rst_if_ack", if_ack, 0);
      checkOutput("rst_ls_en", ls_en, 0);
      checkOutput("rst_ls_we", ls_we, 0);
      checkOutput("rst_ldst_rvalid", ldst_rvalid, 0);
      checkOutput("rst_if_rvalid", if_rvalid, 0);
      checkOutput("rst_ldst_rdata", ldst_rdata, 0);
      checkOutput("rst_rt_out", ldst_rt_addr_out, 0);
      checkOutput("rst_if_rdata", if_rdata, 0);
      stepCycle();
      reset = 1'b0;
      idle();
      stepCycle();
      @(negedge clk);
      checkOutput("post_rst_rvalid", ldst_rvalid, 0);
      stepCycle();

      // Basic load.
      loadCheck("load");

      // Store then load of the same line, different byte offset.
      applyStimulus(1, 1, 32'h0000_0040, {16{8'hA5}}, 7'd0, 0, 32'h0, 0);
      @(negedge clk);
      checkOutput("st_ack", ldst_ack, 1);
      checkOutput("st_ls_we", ls_we, 1);
      checkOutput("st_ls_addr", ls_addr, 11'h004);
      checkOutput("st_ls_wdata", ls_wdata, {16{8'hA5}});
      stepCycle();
      applyStimulus(1, 0, 32'h0000_004C, {16{8'hFF}}, 7'd9, 0, 32'h0, 0);
      @(negedge clk);
      checkOutput("stld_ack", ldst_ack, 1);
      checkOutput("stld_ls_wdata", ls_wdata, 0);
      checkOutput("st_no_rvalid", ldst_rvalid, 0);
      stepCycle();
      idle();
      @(negedge clk);
      checkOutput("st_no_rvalid2", ldst_rvalid, 0);
      stepCycle();
      @(negedge clk);
      checkOutput("stld_rvalid", ldst_rvalid, 1);
      checkOutput("stld_rdata", ldst_rdata, {16{8'hA5}});
      checkOutput("stld_rt", ldst_rt_addr_out, 7'd9);
      stepCycle();

      // Starvation: both requesters held for ten cycles.
      for (int i = 0; i < 12; i++) begin
         if (i < 10) applyStimulus(1, 0, 32'h0000_0300, 128'h0, 7'd3, 1, 32'h0000_0200, 0);
         else        idle();
         @(negedge clk);
         checkOutput($sformatf("starve_ld_ack_%0d", i), ldst_ack, starveLd(i));
         checkOutput($sformatf("starve_if_ack_%0d", i), if_ack, starveIf(i));
         checkOutput($sformatf("starve_ld_rv_%0d", i), ldst_rvalid, starveLd(i - 2));
         checkOutput($sformatf("starve_if_rv_%0d", i), if_rvalid, starveIf(i - 2));
         if (starveIf(i - 2)) checkOutput($sformatf("starve_if_rdata_%0d", i), if_rdata, pattern(12'h020));
         if (starveLd(i - 2)) checkOutput($sformatf("starve_ld_rdata_%0d", i), ldst_rdata, pattern(12'h030));
         stepCycle();
      end

      // Flush cancels the fetch granted the cycle before and blocks fetch in its own cycle.
      applyStimulus(0, 0, 32'h0, 128'h0, 7'd0, 1, 32'h0000_0500, 0);
      @(negedge clk);
      checkOutput("fl_if_ack0", if_ack, 1);
      stepCycle();
      applyStimulus(1, 0, 32'h0000_0123, 128'h0, 7'd7, 1, 32'h0000_0500, 1);
      @(negedge clk);
      checkOutput("fl_if_ack1", if_ack, 0);
      checkOutput("fl_ld_ack1", ldst_ack, 1);
      stepCycle();
      idle();
      @(negedge clk);
      checkOutput("fl_if_rvalid2", if_rvalid, 0);
      stepCycle();
      @(negedge clk);
      checkOutput("fl_if_rvalid3", if_rvalid, 0);
      checkOutput("fl_if_rdata_hold", if_rdata, pattern(12'h020));
      checkOutput("fl_ld_rvalid3", ldst_rvalid, 1);
      checkOutput("fl_ld_rt3", ldst_rt_addr_out, 7'd7);
      stepCycle();

      // Reset mid-operation discards the in-flight load.
      applyStimulus(1, 0, 32'h0000_0123, 128'h0, 7'd5, 0, 32'h0, 0);
      @(negedge clk);
      checkOutput("mr_ack", ldst_ack, 1);
      stepCycle();
      reset = 1'b1;
      applyStimulus(1, 0, 32'h0000_0123, 128'h0, 7'd5, 1, 32'h0, 0);
      @(negedge clk);
      checkOutput("mr_ldst_ack", ldst_ack, 0);
      checkOutput("mr_ls_en", ls_en, 0);
      checkOutput("mr_rvalid", ldst_rvalid, 0);
      checkOutput("mr_rdata", ldst_rdata, 0);
      checkOutput("mr_rt", ldst_rt_addr_out, 0);
      checkOutput("mr_if_rdata", if_rdata, 0);
      stepCycle();
      reset = 1'b0;
      idle();
      @(negedge clk);
      checkOutput("mr_rvalid_after", ldst_rvalid, 0);
      stepCycle();
      @(negedge clk);
      checkOutput("mr_rvalid_after2", ldst_rvalid, 0);
      stepCycle();
      loadCheck("mr_load");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
